// File: rtl/sim_test_ctrl.sv
// End-of-test controller: snoops core data-memory writes, counts cycles/instret, decodes tohost verdicts.
// Optional console byte FIFO on CON_ADDR is enabled by defining SIM_TEST_CTRL_CONSOLE_EN.
module sim_test_ctrl #(
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] TOHOST_ADDR = 32'h0000_1000,
  parameter logic [DATA_WIDTH-1:0] CON_ADDR    = 32'h0000_1004,
  parameter int                    CNT_WIDTH   = 32,
  parameter int                    CON_DEPTH   = 16
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  timeout_cycles,
  input  logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  instr_retired,
  output logic                  running,
  output logic                  done,
  output logic                  pass,
  output logic                  fail,
  output logic                  timed_out,
  output logic [DATA_WIDTH-2:0] fail_code,
  output logic [CNT_WIDTH-1:0]  cycle_count,
  output logic [CNT_WIDTH-1:0]  instret_count,
  output logic                  con_valid,
  output logic [7:0]            con_data,
  input  logic                  con_ready,
  output logic                  con_overflow
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_PASS,
    ST_FAIL,
    ST_TIMEOUT
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t                 state;
  state_t                 state_next;
  logic [CNT_WIDTH-1:0]   timeout_lat;
  logic                   tohost_hit;
  logic                   wd_fire;

  assign tohost_hit = mem_we && (mem_addr == TOHOST_ADDR);
  assign wd_fire    = (timeout_lat != '0) && (cycle_count == timeout_lat - CNT_ONE);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= ST_IDLE;
    else         state <= state_next;
  end

  // A tohost write with bit 0 set takes priority over the watchdog in the same cycle.
  always_comb begin
    state_next = state;
    if (start) begin
      state_next = ST_RUN;
    end else if (state == ST_RUN) begin
      if (tohost_hit && mem_wdata[0]) begin
        if (mem_wdata == DATA_WIDTH'(1)) state_next = ST_PASS;
        else                             state_next = ST_FAIL;
      end else if (wd_fire) begin
        state_next = ST_TIMEOUT;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cycle_count   <= '0;
      instret_count <= '0;
      timeout_lat   <= '0;
      fail_code     <= '0;
    end else if (start) begin
      cycle_count   <= '0;
      instret_count <= '0;
      timeout_lat   <= timeout_cycles;
      fail_code     <= '0;
    end else if (state == ST_RUN) begin
      if (cycle_count != CNT_MAX) cycle_count <= cycle_count + CNT_ONE;
      if (instr_retired && (instret_count != CNT_MAX)) instret_count <= instret_count + CNT_ONE;
      if (state_next == ST_FAIL) fail_code <= mem_wdata[DATA_WIDTH-1:1];
    end
  end

  assign running   = (state == ST_RUN);
  assign pass      = (state == ST_PASS);
  assign fail      = (state == ST_FAIL);
  assign timed_out = (state == ST_TIMEOUT);
  assign done      = pass || fail || timed_out;

`ifdef SIM_TEST_CTRL_CONSOLE_EN
  localparam int AW = $clog2(CON_DEPTH);

  logic [7:0]    fifo_mem [CON_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   fill;
  logic          push_req;
  logic          push;
  logic          pop;
  logic          full;

  assign push_req  = mem_we && (mem_addr == CON_ADDR);
  assign full      = (fill == (AW+1)'(CON_DEPTH));
  assign con_valid = (fill != '0);
  assign pop       = con_valid && con_ready;
  // A simultaneous pop frees the slot, so a push into a full FIFO still succeeds.
  assign push      = push_req && (!full || pop);
  assign con_data  = con_valid ? fifo_mem[rd_ptr] : 8'h00;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= mem_wdata[7:0];
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fill         <= '0;
      con_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fill <= fill + 1'b1;
      else if (pop && !push) fill <= fill - 1'b1;
      if (push_req && !push) con_overflow <= 1'b1;
    end
  end
`else
  logic unused_console;

  assign unused_console = con_ready ^ (mem_addr == CON_ADDR) ^ (CON_DEPTH > 0);
  assign con_valid      = 1'b0;
  assign con_data       = 8'h00;
  assign con_overflow   = 1'b0;
`endif

endmodule

// File: tb/tb_sim_test_ctrl.sv
// Directed self-checking bench for sim_test_ctrl; console checks follow SIM_TEST_CTRL_CONSOLE_EN.
// A second narrow-counter instance exercises counter saturation.
module tb_sim_test_ctrl;

  localparam logic [31:0] TOHOST = 32'h0000_1000;
  localparam logic [31:0] CON    = 32'h0000_1004;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] timeout_cycles = '0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic        instr_retired = 1'b0;
  logic        con_ready = 1'b0;

  logic        running, done, pass, fail, timed_out;
  logic [30:0] fail_code;
  logic [31:0] cycle_count, instret_count;
  logic        con_valid, con_overflow;
  logic [7:0]  con_data;

  logic        s_running, s_done, s_pass, s_fail, s_timed_out;
  logic [30:0] s_fail_code;
  logic [3:0]  s_cycle_count, s_instret_count;
  logic        s_con_valid, s_con_overflow;
  logic [7:0]  s_con_data;

  int checks = 0;
  int errors = 0;

  sim_test_ctrl dut (
    .clk(clk), .arst_n(arst_n), .start(start), .timeout_cycles(timeout_cycles),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .instr_retired(instr_retired), .running(running), .done(done), .pass(pass),
    .fail(fail), .timed_out(timed_out), .fail_code(fail_code),
    .cycle_count(cycle_count), .instret_count(instret_count),
    .con_valid(con_valid), .con_data(con_data), .con_ready(con_ready),
    .con_overflow(con_overflow)
  );

  sim_test_ctrl #(.CNT_WIDTH(4)) dut_small (
    .clk(clk), .arst_n(arst_n), .start(start), .timeout_cycles(4'd0),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .instr_retired(instr_retired), .running(s_running), .done(s_done), .pass(s_pass),
    .fail(s_fail), .timed_out(s_timed_out), .fail_code(s_fail_code),
    .cycle_count(s_cycle_count), .instret_count(s_instret_count),
    .con_valid(s_con_valid), .con_data(s_con_data), .con_ready(con_ready),
    .con_overflow(s_con_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_mem(input logic [31:0] addr, input logic [31:0] data);
    mem_we    = 1'b1;
    mem_addr  = addr;
    mem_wdata = data;
    tick(1);
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
  endtask

  task automatic start_run(input logic [31:0] limit);
    start          = 1'b1;
    timeout_cycles = limit;
    tick(1);
    start          = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_flags"}, 64'({running, done, pass, fail, timed_out}), 64'd0);
    check({tag, "_cycles"}, 64'(cycle_count), 64'd0);
    check({tag, "_instret"}, 64'(instret_count), 64'd0);
    check({tag, "_fail_code"}, 64'(fail_code), 64'd0);
    check({tag, "_console"}, 64'({con_valid, con_data, con_overflow}), 64'd0);
  endtask

  task automatic do_reset(input string tag);
    arst_n = 1'b0;
    #2;
    check_cleared(tag);
    arst_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_cleared("por");
    arst_n = 1'b1;
    tick(1);

    // Test 1: pass after 10 retires, tohost written at cycle 20
    start_run(32'd1000);
    check("t1_running", 64'(running), 64'd1);
    check("t1_cycle0", 64'(cycle_count), 64'd0);
    for (int i = 0; i < 20; i++) begin
      instr_retired = (i < 10);
      tick(1);
    end
    instr_retired = 1'b0;
    check("t1_cycle20", 64'(cycle_count), 64'd20);
    write_mem(TOHOST, 32'h1);
    check("t1_pass", 64'({done, pass, fail, timed_out, running}), 64'b11000);
    check("t1_cycles", 64'(cycle_count), 64'd21);
    check("t1_instret", 64'(instret_count), 64'd10);
    tick(3);
    check("t1_frozen", 64'(cycle_count), 64'd21);

    // Test 2: fail code, later writes ignored
    start_run(32'd0);
    check("t2_restart", 64'({running, done, pass}), 64'b100);
    write_mem(TOHOST, 32'h7);
    check("t2_fail", 64'({done, pass, fail, timed_out}), 64'b1010);
    check("t2_fail_code", 64'(fail_code), 64'd3);
    check("t2_cycles", 64'(cycle_count), 64'd1);
    write_mem(TOHOST, 32'h1);
    check("t2_hold", 64'({pass, fail}), 64'b01);
    check("t2_hold_code", 64'(fail_code), 64'd3);

    // Test 3: watchdog, then tohost beating the watchdog
    start_run(32'd50);
    check("t3_code_cleared", 64'(fail_code), 64'd0);
    tick(49);
    check("t3_cycle49", 64'({running, done}), 64'b10);
    tick(1);
    check("t3_timeout", 64'({done, timed_out, pass, fail}), 64'b1100);
    check("t3_cycles", 64'(cycle_count), 64'd50);
    tick(2);
    check("t3_frozen", 64'(cycle_count), 64'd50);
    start_run(32'd50);
    tick(49);
    write_mem(TOHOST, 32'h1);
    check("t3_pass_wins", 64'({pass, timed_out}), 64'b10);
    check("t3_pass_cycles", 64'(cycle_count), 64'd50);

    // Test 4: ignored writes, pre-start hit, reset mid-run
    start_run(32'd0);
    write_mem(TOHOST, 32'h2);
    check("t4_even_ignored", 64'({running, done}), 64'b10);
    write_mem(CON, 32'h1);
    check("t4_con_write", 64'({running, done}), 64'b10);
    check("t4_cycles", 64'(cycle_count), 64'd2);
`ifdef SIM_TEST_CTRL_CONSOLE_EN
    check("t4_con_pushed", 64'({con_valid, con_data}), 64'h101);
`else
    check("t4_con_tied", 64'({con_valid, con_data, con_overflow}), 64'd0);
`endif
    do_reset("t4_reset_a");
    tick(1);
    write_mem(TOHOST, 32'h1);
    check("t4_prestart", 64'({running, done, pass}), 64'd0);
    instr_retired = 1'b1;
    tick(2);
    instr_retired = 1'b0;
    check("t4_idle_instret", 64'(instret_count), 64'd0);
    start_run(32'd0);
    instr_retired = 1'b1;
    tick(3);
    instr_retired = 1'b0;
    check("t4_mid_instret", 64'(instret_count), 64'd3);
    check("t4_mid_cycles", 64'(cycle_count), 64'd3);
    do_reset("t4_reset_mid");
    tick(1);

    // Test 6: restart during run latches new timeout
    start_run(32'd1000);
    for (int i = 0; i < 30; i++) begin
      instr_retired = (i < 5);
      tick(1);
    end
    instr_retired = 1'b0;
    check("t6_cycle30", 64'(cycle_count), 64'd30);
    check("t6_instret5", 64'(instret_count), 64'd5);
    start_run(32'd5);
    check("t6_restart", 64'({running, cycle_count}), 64'h1_0000_0000);
    check("t6_instret0", 64'(instret_count), 64'd0);
    tick(4);
    check("t6_cycle4", 64'({running, done}), 64'b10);
    tick(1);
    check("t6_timeout", 64'({timed_out, cycle_count}), 64'h1_0000_0005);

    // Saturation of narrow counters
    start_run(32'd0);
    instr_retired = 1'b1;
    tick(20);
    instr_retired = 1'b0;
    check("sat_cycles", 64'(s_cycle_count), 64'hF);
    check("sat_instret", 64'(s_instret_count), 64'hF);
    check("wide_cycles", 64'(cycle_count), 64'd20);

`ifdef SIM_TEST_CTRL_CONSOLE_EN
    // Test 5: console overflow and in-order drain
    do_reset("t5_reset");
    con_ready = 1'b0;
    for (int i = 0; i < 17; i++) write_mem(CON, 32'h41 + 32'(i));
    check("t5_full", 64'({con_valid, con_data}), 64'h141);
    check("t5_overflow", 64'(con_overflow), 64'd1);
    start_run(32'd0);
    check("t5_no_flush", 64'({con_valid, con_data}), 64'h141);
    con_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("t5_drain", 64'({con_valid, con_data}), 64'(9'h100 | (9'h41 + 9'(i))));
      tick(1);
    end
    con_ready = 1'b0;
    check("t5_empty", 64'(con_valid), 64'd0);
    check("t5_sticky", 64'(con_overflow), 64'd1);

    do_reset("t5_reset_b");
    for (int i = 0; i < 16; i++) write_mem(CON, 32'h60 + 32'(i));
    check("t5_full_no_ovf", 64'({con_valid, con_overflow}), 64'b10);
    con_ready = 1'b1;
    write_mem(CON, 32'h70);
    con_ready = 1'b0;
    check("t5_pushpop_ovf", 64'(con_overflow), 64'd0);
    check("t5_pushpop_head", 64'(con_data), 64'h61);
    con_ready = 1'b1;
    tick(15);
    check("t5_last", 64'({con_valid, con_data}), 64'h170);
    tick(1);
    con_ready = 1'b0;
    check("t5_drained", 64'(con_valid), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
